drop_scheduler: RTL

DROP_SCHEDULER -- requirements
Module: drop_scheduler

---
 rtl/drop_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/drop_scheduler.sv
// rtl/drop_scheduler.sv - four-slot falling-object scheduler with LFSR spawns, landing/catch scoring
module drop_scheduler #(
  parameter int STEP      = 4,
  parameter int FLOOR_Y   = 400,
  parameter int SPAWN_GAP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic        tick,
  input  logic [2:0]  farmer_x,
  output logic [11:0] obj_x,
  output logic [39:0] obj_y,
  output logic [3:0]  obj_active,
  output logic [5:0]  score_pos,
  output logic [5:0]  score_neg,
  output logic        catch_pulse
);

  localparam logic [9:0]  Y_OFF     = 10'd480;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [3:0]       act_q, act_d;
  logic [3:0][2:0]  x_q, x_d;
  logic [3:0][9:0]  y_q, y_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [5:0]       sp_q, sp_d;
  logic [5:0]       sn_q, sn_d;
  logic             pulse_q, pulse_d;

  logic             valid;
  logic [10:0]      nxt_y;
  logic [1:0]       n_fruit;
  logic             n_bug;
  logic [1:0]       slot;
  logic [6:0]       sp_sum;
  logic [6:0]       sn_sum;

  assign valid = enable & tick;

  always_comb begin
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    sp_d    = sp_q;
    sn_d    = sn_q;
    pulse_d = 1'b0;
    nxt_y   = '0;
    n_fruit = '0;
    n_bug   = 1'b0;
    slot    = lfsr_q[4:3];
    sp_sum  = '0;
    sn_sum  = '0;
    if (valid) begin
      for (int i = 0; i < 4; i++) begin
        if (act_q[i]) begin
          nxt_y = {1'b0, y_q[i]} + 11'(STEP);
          if (nxt_y >= 11'(FLOOR_Y)) begin
            act_d[i] = 1'b0;
            y_d[i]   = Y_OFF;
            x_d[i]   = 3'd0;
            if (x_q[i] == farmer_x) begin
              if (i == 0) n_bug = 1'b1;
              else        n_fruit = n_fruit + 2'd1;
            end
          end else begin
            y_d[i] = nxt_y[9:0];
          end
        end
      end
      // Spawn looks only at pre-tick occupancy, so a slot landing now stays free this tick.
      if (cnt_q == 10'(SPAWN_GAP - 1)) begin
        cnt_d  = '0;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (!act_q[slot]) begin
          act_d[slot] = 1'b1;
          x_d[slot]   = lfsr_q[2:0];
          y_d[slot]   = 10'd0;
        end
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
      sp_sum  = {1'b0, sp_q} + {5'b0, n_fruit};
      sn_sum  = {1'b0, sn_q} + {6'b0, n_bug};
      sp_d    = sp_sum[6] ? 6'd63 : sp_sum[5:0];
      sn_d    = sn_sum[6] ? 6'd63 : sn_sum[5:0];
      pulse_d = n_bug | (n_fruit != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q   <= '0;
      x_q     <= '0;
      y_q     <= {4{Y_OFF}};
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      sp_q    <= '0;
      sn_q    <= '0;
      pulse_q <= 1'b0;
    end else if (clear) begin
      act_q   <= '0;
      x_q     <= '0;
      y_q     <= {4{Y_OFF}};
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      sp_q    <= '0;
      sn_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      sp_q    <= sp_d;
      sn_q    <= sn_d;
      pulse_q <= pulse_d;
    end
  end

  assign obj_active  = act_q;
  assign obj_x       = x_q;
  assign obj_y       = y_q;
  assign score_pos   = sp_q;
  assign score_neg   = sn_q;
  assign catch_pulse = pulse_q;

endmodule
